// File: rtl/canbus_pkg.sv
// canbus_pkg: shared widths, scheduler state encoding and tx result decode
// for the CAN transmit scheduler.
package canbus_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DATA_W = 32;
  localparam int RETRY_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    TX_OK       = 2'd0,
    TX_ARB_LOST = 2'd1,
    TX_ACK_ERR  = 2'd2
  } tx_res_t;

  // Arbitration loss dominates. A frame that lost the bus never reached
  // its ACK slot, so its ACK flag means nothing.
  function automatic tx_res_t tx_result(input logic arb_lost, input logic ack_err);
    if (arb_lost)     return TX_ARB_LOST;
    else if (ack_err) return TX_ACK_ERR;
    else              return TX_OK;
  endfunction

endpackage

// File: rtl/canbus_prio_select.sv
// canbus_prio_select: combinational CAN-priority pick over mailbox slots.
//   pending  in  NUM_MBOX            slot valid mask
//   ids      in  NUM_MBOX x 11       slot IDs
//   win_idx  out $clog2(NUM_MBOX)    lowest-ID pending slot, lowest index on ties
//   any      out 1                   at least one slot pending
module canbus_prio_select
  import canbus_pkg::*;
#(
  parameter int NUM_MBOX = 4,
  parameter int IDX_W    = $clog2(NUM_MBOX)
) (
  input  logic [NUM_MBOX-1:0]               pending,
  input  logic [NUM_MBOX-1:0][CAN_ID_W-1:0] ids,
  output logic [IDX_W-1:0]                  win_idx,
  output logic                              any
);

  logic [CAN_ID_W-1:0] best;

  // Scan upward and replace only on strictly lower ID, so ties keep the
  // lower index.
  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    best    = '1;
    for (int i = 0; i < NUM_MBOX; i++) begin
      if (pending[i] && (!any || ids[i] < best)) begin
        any     = 1'b1;
        win_idx = IDX_W'(i);
        best    = ids[i];
      end
    end
  end

endmodule

// File: rtl/canbus_tx_scheduler.sv
// canbus_tx_scheduler: shares one CAN tx engine between NUM_MBOX mailboxes.
// It latches frames, launches the lowest pending ID, retries after ACK
// errors (at most MAX_RETRY) and after lost arbitration (no limit), and
// enforces an IFS_BITS interframe gap before each re-selection.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   mb_wr/mb_id/mb_data                per-slot write strobe, ID, payload
//   mb_pending/mb_done/mb_err          slot status, done/drop pulses
//   tx_start/tx_id/tx_data             launch strobe and held frame
//   tx_busy/tx_done/tx_arb_lost/tx_ack_err   engine status/result
// Optional: define CANBUS_SCHED_TIMEOUT_EN to drop a frame whose tx_done
// never arrives within TO_BITS bit times.
module canbus_tx_scheduler
  import canbus_pkg::*;
#(
  parameter int NUM_MBOX  = 4,
  parameter int DIVIDER   = 53,
  parameter int IFS_BITS  = 3,
  parameter int MAX_RETRY = 7,
  parameter int TO_BITS   = 160
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_MBOX-1:0]        mb_wr,
  input  logic [NUM_MBOX*11-1:0]     mb_id,
  input  logic [NUM_MBOX*32-1:0]     mb_data,
  output logic [NUM_MBOX-1:0]        mb_pending,
  output logic [NUM_MBOX-1:0]        mb_done,
  output logic [NUM_MBOX-1:0]        mb_err,
  output logic                       tx_start,
  output logic [CAN_ID_W-1:0]        tx_id,
  output logic [CAN_DATA_W-1:0]      tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  input  logic                       tx_arb_lost,
  input  logic                       tx_ack_err
);

  localparam int IDX_W   = $clog2(NUM_MBOX);
  localparam int BIT_CYC = 2 * (DIVIDER + 1);
  localparam int GAP_CYC = IFS_BITS * BIT_CYC;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  // Flat port buses share the packed-array layout: slot i at [W*i +: W].
  logic [NUM_MBOX-1:0][CAN_ID_W-1:0]   wr_id;
  logic [NUM_MBOX-1:0][CAN_DATA_W-1:0] wr_data;
  assign wr_id   = mb_id;
  assign wr_data = mb_data;

  logic [NUM_MBOX-1:0][CAN_ID_W-1:0]   slot_id;
  logic [NUM_MBOX-1:0][CAN_DATA_W-1:0] slot_data;
  logic [NUM_MBOX-1:0][RETRY_W-1:0]    slot_retry;
  logic [NUM_MBOX-1:0]                 pending;

  sched_state_t      state, state_nx;
  logic [IDX_W-1:0]  act_idx;
  logic [GAP_W-1:0]  gap_cnt;

  logic [IDX_W-1:0]  win_idx;
  logic              any_pend;

  logic latch_sel, start_nx;
  logic fin_ok, fin_ack, fin_to;
  logic drop_act, clr_act, inc_act, busy_slot;
  logic [NUM_MBOX-1:0] act_oh;

  canbus_prio_select #(.NUM_MBOX(NUM_MBOX), .IDX_W(IDX_W)) u_sel (
    .pending (pending),
    .ids     (slot_id),
    .win_idx (win_idx),
    .any     (any_pend)
  );

`ifdef CANBUS_SCHED_TIMEOUT_EN
  localparam int TO_CYC = TO_BITS * BIT_CYC;
  localparam int TO_W   = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // Counts WAIT cycles from the tx_start cycle. It holds at its ceiling
  // rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     to_cnt <= '0;
    else if (state != S_WAIT)       to_cnt <= '0;
    else if (to_cnt != TO_W'(TO_CYC)) to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (to_cnt == TO_W'(TO_CYC - 1));
`endif

  // While the slot is in LAUNCH or WAIT, it owns the engine. A write to it
  // would change the frame the engine is sending.
  assign busy_slot = (state == S_LAUNCH) || (state == S_WAIT);
  assign act_oh    = {{(NUM_MBOX-1){1'b0}}, 1'b1} << act_idx;
  assign drop_act  = (fin_ack && slot_retry[act_idx] == RETRY_W'(MAX_RETRY)) || fin_to;
  assign clr_act   = fin_ok || drop_act;
  assign inc_act   = fin_ack && !drop_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    latch_sel = 1'b0;
    start_nx  = 1'b0;
    fin_ok    = 1'b0;
    fin_ack   = 1'b0;
    fin_to    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_pend) begin
          latch_sel = 1'b1;
          state_nx  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!tx_busy) begin
          start_nx = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          // Lost arbitration needs no action: the slot stays pending and
          // keeps its retry count.
          case (tx_result(tx_arb_lost, tx_ack_err))
            TX_OK:      fin_ok  = 1'b1;
            TX_ACK_ERR: fin_ack = 1'b1;
            default:    ;
          endcase
          state_nx = S_GAP;
        end
`ifdef CANBUS_SCHED_TIMEOUT_EN
        else if (to_hit) begin
          fin_to   = 1'b1;
          state_nx = S_GAP;
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Slot storage. A write takes priority over the result of the active
  // frame, and a new frame starts with a fresh retry budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_id    <= '0;
      slot_data  <= '0;
      slot_retry <= '0;
      pending    <= '0;
    end else begin
      for (int i = 0; i < NUM_MBOX; i++) begin
        if (mb_wr[i] && !(busy_slot && act_idx == IDX_W'(i))) begin
          slot_id[i]    <= wr_id[i];
          slot_data[i]  <= wr_data[i];
          slot_retry[i] <= '0;
          pending[i]    <= 1'b1;
        end else if (act_idx == IDX_W'(i)) begin
          if (clr_act) begin
            pending[i]    <= 1'b0;
            slot_retry[i] <= '0;
          end else if (inc_act && slot_retry[i] != '1) begin
            slot_retry[i] <= slot_retry[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         gap_cnt <= '0;
    else if (state != S_GAP)            gap_cnt <= '0;
    else if (gap_cnt != GAP_W'(GAP_CYC)) gap_cnt <= gap_cnt + 1'b1;
  end

  // tx_id/tx_data change only on selection, so they stay stable from
  // tx_start until tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_idx  <= '0;
      tx_id    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      mb_done  <= '0;
      mb_err   <= '0;
    end else begin
      if (latch_sel) begin
        act_idx <= win_idx;
        tx_id   <= slot_id[win_idx];
        tx_data <= slot_data[win_idx];
      end
      tx_start <= start_nx;
      mb_done  <= fin_ok   ? act_oh : '0;
      mb_err   <= drop_act ? act_oh : '0;
    end
  end

  assign mb_pending = pending;

endmodule

// File: tb/tb_canbus_tx_scheduler.sv
// Directed bench for canbus_tx_scheduler. Expected launches are queued when
// frames are written and popped on each tx_start.
module tb_canbus_tx_scheduler;

  localparam int NM      = 4;
  localparam int DIV     = 53;
  localparam int IFS     = 3;
  localparam int MR      = 7;
  localparam int TOB     = 160;
  localparam int BIT_CYC = 2 * (DIV + 1);
  localparam int GAP_CYC = IFS * BIT_CYC;
  localparam int TO_CYC  = TOB * BIT_CYC;

  logic              clk, rst_n;
  logic [NM-1:0]     mb_wr;
  logic [NM*11-1:0]  mb_id;
  logic [NM*32-1:0]  mb_data;
  logic [NM-1:0]     mb_pending, mb_done, mb_err;
  logic              tx_start;
  logic [10:0]       tx_id;
  logic [31:0]       tx_data;
  logic              tx_busy, tx_done, tx_arb_lost, tx_ack_err;

  canbus_tx_scheduler #(
    .NUM_MBOX(NM), .DIVIDER(DIV), .IFS_BITS(IFS), .MAX_RETRY(MR), .TO_BITS(TOB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mb_wr(mb_wr), .mb_id(mb_id), .mb_data(mb_data),
    .mb_pending(mb_pending), .mb_done(mb_done), .mb_err(mb_err),
    .tx_start(tx_start), .tx_id(tx_id), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_arb_lost(tx_arb_lost), .tx_ack_err(tx_ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_start = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) n_start <= n_start + 1;
  end

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int          idx;
    logic [10:0] id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cur_idx = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NM-1:0] oh(input int i);
    return NM'(1) << i;
  endfunction

  task automatic push(input int idx, input logic [10:0] id, input logic [31:0] data);
    sb.push_back('{idx, id, data});
  endtask

  task automatic write1(input int idx, input logic [10:0] id, input logic [31:0] data);
    @(negedge clk);
    mb_wr = '0;
    mb_wr[idx] = 1'b1;
    mb_id[11*idx +: 11]   = id;
    mb_data[32*idx +: 32] = data;
    @(negedge clk);
    mb_wr = '0;
  endtask

  // Waits (bounded) for the next tx_start and checks it against the scoreboard.
  task automatic wait_start(output int st);
    bit seen;
    seen = 1'b0;
    st   = -1;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    if (!seen) chk("start_seen", 64'd0, 64'd1);
    else if (sb.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
    else begin
      exp_t e;
      e = sb.pop_front();
      cur_idx = e.idx;
      st = cyc;
      chk("tx_id", 64'(tx_id), 64'(e.id));
      chk("tx_data", 64'(tx_data), 64'(e.data));
    end
  endtask

  task automatic finish(input logic arb, input logic ack, output int dc);
    @(negedge clk);
    tx_done = 1'b1; tx_arb_lost = arb; tx_ack_err = ack;
    dc = cyc;
    @(negedge clk);
    tx_done = 1'b0; tx_arb_lost = 1'b0; tx_ack_err = 1'b0;
  endtask

  initial begin
    int   st, dc, dc_prev, base;
    bit   got;
    exp_t e;

    rst_n = 1'b0; mb_wr = '0; mb_id = '0; mb_data = '0;
    tx_busy = 1'b0; tx_done = 1'b0; tx_arb_lost = 1'b0; tx_ack_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pending", 64'(mb_pending), 64'd0);
    chk("rst_done",    64'(mb_done),    64'd0);
    chk("rst_err",     64'(mb_err),     64'd0);
    chk("rst_start",   64'(tx_start),   64'd0);
    chk("rst_id",      64'(tx_id),      64'd0);
    chk("rst_data",    64'(tx_data),    64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: latency N+3 from the write cycle.
    push(2, 11'h00d, 32'hDEADBEEF);
    base = n_start;
    mb_wr = 4'b0100; mb_id[22 +: 11] = 11'h00d; mb_data[64 +: 32] = 32'hDEADBEEF;
    @(negedge clk); mb_wr = '0;
    chk("single_pend_n1", 64'(mb_pending), 64'h4);
    @(negedge clk);
    chk("single_start_n2", 64'(tx_start), 64'd0);
    @(negedge clk);
    chk("single_start_n3", 64'(tx_start), 64'd1);
    e = sb.pop_front();
    chk("single_id",   64'(tx_id),   64'(e.id));
    chk("single_data", 64'(tx_data), 64'(e.data));
    finish(1'b0, 1'b0, dc);
    chk("single_done", 64'(mb_done),    64'(oh(e.idx)));
    chk("single_pend", 64'(mb_pending), 64'd0);
    chk("single_err",  64'(mb_err),     64'd0);
    repeat (GAP_CYC + 10) @(negedge clk);
    chk("single_starts", 64'(n_start - base), 64'd1);

    // Priority with a tie, plus an overwrite and an ignored active write.
    @(negedge clk);
    mb_wr = 4'b1011;
    mb_id[0 +: 11]  = 11'h120; mb_data[0 +: 32]  = 32'hA0A0A0A0;
    mb_id[11 +: 11] = 11'h009; mb_data[32 +: 32] = 32'hA1A1A1A1;
    mb_id[33 +: 11] = 11'h009; mb_data[96 +: 32] = 32'hA3A3A3A3;
    push(1, 11'h009, 32'hA1A1A1A1);
    @(negedge clk); mb_wr = '0;
    wait_start(st);
    mb_wr = 4'b0011;
    mb_id[0 +: 11]  = 11'h005; mb_data[0 +: 32]  = 32'hB0B0B0B0;
    mb_id[11 +: 11] = 11'h001; mb_data[32 +: 32] = 32'hFFFFFFFF;
    @(negedge clk); mb_wr = '0;
    chk("active_wr_data", 64'(tx_data), 64'hA1A1A1A1);
    chk("active_wr_id",   64'(tx_id),   64'h009);
    push(0, 11'h005, 32'hB0B0B0B0);
    push(3, 11'h009, 32'hA3A3A3A3);
    finish(1'b0, 1'b0, dc);
    chk("prio1_done", 64'(mb_done),    64'(oh(cur_idx)));
    chk("prio1_pend", 64'(mb_pending), 64'h9);
    wait_start(st);
    finish(1'b0, 1'b0, dc);
    chk("prio2_done", 64'(mb_done), 64'(oh(cur_idx)));
    wait_start(st);
    finish(1'b0, 1'b0, dc);
    chk("prio3_done", 64'(mb_done),    64'(oh(cur_idx)));
    chk("prio3_pend", 64'(mb_pending), 64'd0);
    repeat (GAP_CYC + 5) @(negedge clk);

    // A busy engine holds the launch; then ACK errors exhaust the retries.
    tx_busy = 1'b1;
    base = n_start;
    write1(2, 11'h100, 32'hC2C2C2C2);
    repeat (10) @(negedge clk);
    chk("busy_hold", 64'(n_start - base), 64'd0);
    for (int k = 0; k <= MR; k++) push(2, 11'h100, 32'hC2C2C2C2);
    tx_busy = 1'b0;
    for (int k = 0; k <= MR; k++) begin
      wait_start(st);
      finish(1'b0, 1'b1, dc);
      if (k < MR) begin
        chk("ack_err_early", 64'(mb_err),     64'd0);
        chk("ack_pend",      64'(mb_pending), 64'h4);
      end else begin
        chk("ack_err_final", 64'(mb_err),     64'h4);
        chk("ack_pend_final", 64'(mb_pending), 64'd0);
      end
    end
    repeat (GAP_CYC + 10) @(negedge clk);
    chk("ack_starts", 64'(n_start - base), 64'(MR + 1));

    // Lost arbitration never counts as a retry, even with ACK error also set.
    write1(1, 11'h050, 32'hD1D1D1D1);
    for (int k = 0; k < 21; k++) push(1, 11'h050, 32'hD1D1D1D1);
    dc_prev = 0;
    for (int k = 0; k < 21; k++) begin
      wait_start(st);
      if (k == 1) chk("gap_cycles", 64'(st - dc_prev), 64'(GAP_CYC + 3));
      if (k < 20) begin
        finish(1'b1, logic'(k % 2), dc);
        chk("arb_err",  64'(mb_err),     64'd0);
        chk("arb_pend", 64'(mb_pending), 64'h2);
      end else begin
        finish(1'b0, 1'b0, dc);
        chk("arb_done", 64'(mb_done),    64'h2);
        chk("arb_err_final", 64'(mb_err), 64'd0);
        chk("arb_pend_final", 64'(mb_pending), 64'd0);
      end
      dc_prev = dc;
    end

    // tx_done outside WAIT has no effect.
    repeat (GAP_CYC + 5) @(negedge clk);
    finish(1'b0, 1'b0, dc);
    chk("stray_done", 64'(mb_done), 64'd0);
    chk("stray_err",  64'(mb_err),  64'd0);

`ifdef CANBUS_SCHED_TIMEOUT_EN
    write1(3, 11'h033, 32'h33333333);
    push(3, 11'h033, 32'h33333333);
    wait_start(st);
    got = 1'b0;
    for (int k = 0; k < TO_CYC + 20 && !got; k++) begin
      @(negedge clk);
      if (mb_err != '0) got = 1'b1;
    end
    chk("to_seen",  64'(got),        64'd1);
    chk("to_delay", 64'(cyc - st),   64'(TO_CYC));
    chk("to_err",   64'(mb_err),     64'h8);
    repeat (2) @(negedge clk);
    chk("to_pend",  64'(mb_pending), 64'd0);
    repeat (GAP_CYC + 5) @(negedge clk);
`endif

    // An async reset in WAIT clears the outputs without waiting for an edge.
    write1(0, 11'h010, 32'hE0E0E0E0);
    push(0, 11'h010, 32'hE0E0E0E0);
    wait_start(st);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 64'(tx_start),   64'd0);
    chk("arst_id",    64'(tx_id),      64'd0);
    chk("arst_data",  64'(tx_data),    64'd0);
    chk("arst_pend",  64'(mb_pending), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_start;
    repeat (10) @(negedge clk);
    chk("arst_idle", 64'(n_start - base), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
